axis_lrelu_sequencer: RTL and testbench

Front-end sequencer for the next-generation LReLU path. It splits one wide AXI-Stream from the conv engine into two paths, in strict order per iteration:
- a full-width config path, with a per-kernel-size beat count;
- a MEMBERS:1 width-reducing data path.

Between iterations it drains, pulses a config clear, and optionally holds for a BRAM fill delay. It supports up to 2^KW_BITS kernel modes selected from tuser, and flags protocol errors.

---
 rtl/axis_lrelu_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_axis_lrelu_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_lrelu_sequencer.sv
// axis_lrelu_sequencer: front-end sequencer for the LReLU path.
// Each iteration it routes a wide AXI-Stream first to the full-width config
// path (beat count chosen by the kernel code in tuser), optionally holds for
// a BRAM fill delay, then narrows the data beats MEMBERS:1 onto the data path.
// It drains, pulses cfg_clear and starts over. An early tlast seen during
// config is reported on err_cfg_last.
module axis_lrelu_sequencer #(
    parameter int unsigned                  WORD_WIDTH  = 32,
    parameter int unsigned                  LANES       = 32,
    parameter int unsigned                  MEMBERS     = 2,
    parameter int unsigned                  TUSER_WIDTH = 8,
    parameter int unsigned                  I_KW        = 5,
    parameter int unsigned                  KW_BITS     = 2,
    parameter logic [8*(2**KW_BITS)-1:0]    CFG_BEATS   = {8'd37, 8'd29, 8'd21, 8'd13},
    parameter logic [(2**KW_BITS)-1:0]      FILL_MASK   = 4'b0001,
    parameter int unsigned                  FILL_DELAY  = 3
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [MEMBERS*LANES*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
    input  logic                                  s_axis_tlast,
    output logic                                  m_data_tvalid,
    input  logic                                  m_data_tready,
    output logic [LANES*WORD_WIDTH-1:0]           m_data_tdata,
    output logic [TUSER_WIDTH-1:0]                m_data_tuser,
    output logic                                  m_data_tlast,
    output logic                                  m_cfg_tvalid,
    input  logic                                  m_cfg_tready,
    output logic [MEMBERS*LANES*WORD_WIDTH-1:0]   m_cfg_tdata,
    output logic                                  m_cfg_tlast,
    output logic [KW_BITS-1:0]                    m_cfg_kernel,
    output logic                                  cfg_clear,
    output logic                                  err_cfg_last
);

    localparam int unsigned NW  = LANES * WORD_WIDTH;
    localparam int unsigned WW  = MEMBERS * NW;
    localparam int unsigned NK  = 2 ** KW_BITS;
    localparam int unsigned MCW = (MEMBERS > 1) ? $clog2(MEMBERS) : 1;
    localparam int unsigned FCW = (FILL_DELAY > 1) ? $clog2(FILL_DELAY) : 1;

    localparam logic [MCW-1:0] MC_LAST = MCW'(MEMBERS - 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FILL_DELAY - 1);

    localparam logic [2:0] S_CFG_FIRST = 3'd0;
    localparam logic [2:0] S_CFG_REST  = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_PASS      = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_CLEAR     = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [FCW-1:0]         fcnt_q, fcnt_d;
    logic [KW_BITS-1:0]     kernel_q, kernel_d;
    logic                   err_q, err_d;

    logic [WW-1:0]          buf_q;
    logic [TUSER_WIDTH-1:0] buf_user_q;
    logic                   buf_last_q;
    logic                   buf_valid_q, buf_valid_d;
    logic [MCW-1:0]         mc_q, mc_d;

    logic                   in_cfg;
    logic                   mc_is_last;
    logic                   s_ready;
    logic                   cfg_hs;
    logic                   wide_hs;
    logic                   nar_hs;
    logic [KW_BITS-1:0]     k_in;
    logic [7:0]             beats_in;

    assign in_cfg     = (state_q == S_CFG_FIRST) || (state_q == S_CFG_REST);
    assign mc_is_last = (mc_q == MC_LAST);
    assign nar_hs     = buf_valid_q && m_data_tready;
    assign cfg_hs     = in_cfg && s_axis_tvalid && s_ready;
    assign wide_hs    = (state_q == S_PASS) && s_axis_tvalid && s_ready;
    assign k_in       = s_axis_tuser[I_KW +: KW_BITS];

    // Total config beat count for the kernel code arriving on tuser.
    always_comb begin
        beats_in = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (k_in == KW_BITS'(i)) begin
                beats_in = CFG_BEATS[i*8 +: 8];
            end
        end
    end

    // Input ready: config passthrough, or holding register free / freeing.
    always_comb begin
        s_ready = 1'b0;
        if (!areset) begin
            case (state_q)
                S_CFG_FIRST, S_CFG_REST: s_ready = m_cfg_tready;
                S_PASS:                  s_ready = !buf_valid_q || (m_data_tready && mc_is_last);
                default:                 s_ready = 1'b0;
            endcase
        end
    end

    // Sequencer next-state, beat counters and kernel latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        kernel_d = kernel_q;
        err_d    = cfg_hs && s_axis_tlast && ((state_q == S_CFG_FIRST) || (cnt_q != 8'd0));
        case (state_q)
            S_CFG_FIRST: begin
                if (cfg_hs) begin
                    kernel_d = k_in;
                    cnt_d    = beats_in - 8'd2;
                    state_d  = S_CFG_REST;
                end
            end
            S_CFG_REST: begin
                if (cfg_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = FILL_MASK[kernel_q] ? S_FILL : S_PASS;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_FILL: begin
                if (m_data_tready) begin
                    if (fcnt_q == FC_LAST) begin
                        fcnt_d  = '0;
                        state_d = S_PASS;
                    end else begin
                        fcnt_d = fcnt_q + FCW'(1);
                    end
                end
            end
            S_PASS: begin
                if (wide_hs && s_axis_tlast) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (nar_hs && m_data_tlast) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_CFG_FIRST;
            end
            default: begin
                state_d = S_CFG_FIRST;
            end
        endcase
    end

    // Holding-register occupancy and member index; a refill on the cycle the
    // last member leaves keeps the narrow stream bubble-free.
    always_comb begin
        buf_valid_d = buf_valid_q;
        mc_d        = mc_q;
        if (nar_hs) begin
            if (mc_is_last) begin
                mc_d        = '0;
                buf_valid_d = 1'b0;
            end else begin
                mc_d = mc_q + MCW'(1);
            end
        end
        if (wide_hs) begin
            buf_valid_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_CFG_FIRST;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            kernel_q    <= '0;
            err_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            mc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            kernel_q    <= kernel_d;
            err_q       <= err_d;
            buf_valid_q <= buf_valid_d;
            mc_q        <= mc_d;
        end
    end

    // Wide beat capture; contents are qualified by buf_valid_q.
    always_ff @(posedge aclk) begin
        if (wide_hs) begin
            buf_q      <= s_axis_tdata;
            buf_user_q <= s_axis_tuser;
            buf_last_q <= s_axis_tlast;
        end
    end

    // Member select for the narrow data output.
    always_comb begin
        m_data_tdata = '0;
        for (int unsigned m = 0; m < MEMBERS; m++) begin
            if (mc_q == MCW'(m)) begin
                m_data_tdata = buf_q[m*NW +: NW];
            end
        end
    end

    assign s_axis_tready = s_ready;
    assign m_data_tvalid = buf_valid_q;
    assign m_data_tuser  = buf_user_q;
    assign m_data_tlast  = buf_last_q && mc_is_last;
    assign m_cfg_tvalid  = in_cfg && s_axis_tvalid;
    assign m_cfg_tdata   = s_axis_tdata;
    assign m_cfg_tlast   = (state_q == S_CFG_REST) && (cnt_q == 8'd0);
    assign m_cfg_kernel  = kernel_q;
    assign cfg_clear     = (state_q == S_CLEAR);
    assign err_cfg_last  = err_q;

endmodule

// File: tb/tb_axis_lrelu_sequencer.sv
// Scoreboard bench for axis_lrelu_sequencer with a narrowed word geometry
// (8-bit words, 4 lanes, 2 members) and the default kernel/fill tables.
module tb_axis_lrelu_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tuser;
    logic        s_axis_tlast;
    logic        m_data_tvalid;
    logic        m_data_tready;
    logic [31:0] m_data_tdata;
    logic [7:0]  m_data_tuser;
    logic        m_data_tlast;
    logic        m_cfg_tvalid;
    logic        m_cfg_tready;
    logic [63:0] m_cfg_tdata;
    logic        m_cfg_tlast;
    logic [1:0]  m_cfg_kernel;
    logic        cfg_clear;
    logic        err_cfg_last;

    always #5 aclk = ~aclk;

    axis_lrelu_sequencer #(
        .WORD_WIDTH (8),
        .LANES      (4),
        .MEMBERS    (2),
        .TUSER_WIDTH(8),
        .I_KW       (5),
        .KW_BITS    (2),
        .CFG_BEATS  ({8'd37, 8'd29, 8'd21, 8'd13}),
        .FILL_MASK  (4'b0001),
        .FILL_DELAY (3)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .m_data_tvalid(m_data_tvalid),
        .m_data_tready(m_data_tready),
        .m_data_tdata (m_data_tdata),
        .m_data_tuser (m_data_tuser),
        .m_data_tlast (m_data_tlast),
        .m_cfg_tvalid (m_cfg_tvalid),
        .m_cfg_tready (m_cfg_tready),
        .m_cfg_tdata  (m_cfg_tdata),
        .m_cfg_tlast  (m_cfg_tlast),
        .m_cfg_kernel (m_cfg_kernel),
        .cfg_clear    (cfg_clear),
        .err_cfg_last (err_cfg_last)
    );

    typedef struct { logic [31:0] d; logic [7:0] u; logic l; } nar_t;
    typedef struct { logic [63:0] d; logic l; } cfg_t;

    nar_t nar_exp[$];
    cfg_t cfg_exp[$];
    int   nar_cyc[$];
    int   vec = 0;
    int   mis = 0;
    int   cyc = 0;
    int   cfg_n = 0;
    int   err_n = 0;
    int   clr_n = 0;
    nar_t mon_n;
    cfg_t mon_c;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a handshake is presented.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_cfg_tvalid && m_cfg_tready) begin
                cfg_n++;
                if (cfg_exp.size() == 0) begin
                    vec++; mis++;
                    $display("FAIL cfg_unexpected: got beat %h expected none", m_cfg_tdata);
                end else begin
                    mon_c = cfg_exp.pop_front();
                    chk("cfg_data", m_cfg_tdata, mon_c.d);
                    chk("cfg_tlast", {63'd0, m_cfg_tlast}, {63'd0, mon_c.l});
                end
            end
            if (m_data_tvalid && m_data_tready) begin
                nar_cyc.push_back(cyc);
                if (nar_exp.size() == 0) begin
                    vec++; mis++;
                    $display("FAIL nar_unexpected: got beat %h expected none", m_data_tdata);
                end else begin
                    mon_n = nar_exp.pop_front();
                    chk("nar_beat", {23'd0, m_data_tdata, m_data_tuser, m_data_tlast},
                                    {23'd0, mon_n.d, mon_n.u, mon_n.l});
                end
            end
            if (err_cfg_last) err_n++;
            if (cfg_clear) clr_n++;
        end
    end

    // Present one wide beat, called just after a rising edge; returns just
    // after the edge on which it was accepted.
    task automatic put(input logic [63:0] d, input logic [7:0] u, input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            vec++; mis++;
            $display("FAIL put_timeout: tready stayed 0, required 1");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic cfg_iter(input logic [7:0] u0, input int n, input int tl_at);
        logic [63:0] d;
        cfg_t        e;
        for (int i = 1; i <= n; i++) begin
            d   = {16'hC0F1, 8'(n), 8'(i), 16'h5A5A, 8'(i), 8'(n)};
            e.d = d;
            e.l = (i == n);
            cfg_exp.push_back(e);
            put(d, (i == 1) ? u0 : 8'h7F, (i == tl_at));
            if (i == tl_at) chk("err_pulse", {63'd0, err_cfg_last}, 64'd1);
        end
    endtask

    task automatic pass_beat(input logic [31:0] lo, input logic [31:0] hi,
                             input logic [7:0] u, input logic l);
        nar_t e;
        e.d = lo; e.u = u; e.l = 1'b0;
        nar_exp.push_back(e);
        e.d = hi; e.u = u; e.l = l;
        nar_exp.push_back(e);
        put({hi, lo}, u, l);
    endtask

    task automatic fill_len(input bit tog, output int n);
        n = 0;
        if (tog) m_data_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (s_axis_tready) break;
            n++;
            @(posedge aclk);
            #1;
            if (tog) m_data_tready = ~m_data_tready;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        @(negedge aclk);
        while (!cfg_clear && n < 60) begin
            @(negedge aclk);
            n++;
        end
        chk("clear_seen", {63'd0, cfg_clear}, 64'd1);
    endtask

    logic [31:0] a_lo [4] = '{32'hA0A0_0010, 32'hB1B1_0020, 32'hC2C2_0030, 32'hD3D3_0040};
    logic [31:0] a_hi [4] = '{32'hA0A0_0011, 32'hB1B1_0021, 32'hC2C2_0031, 32'hD3D3_0041};
    logic [7:0]  a_u  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int fl;
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_data_tready = 1'b1;
        m_cfg_tready  = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst_state", {59'd0, m_data_tvalid, m_cfg_tvalid, cfg_clear, err_cfg_last, 1'b0}, 64'd0);
        chk("rst_kernel", {62'd0, m_cfg_kernel}, 64'd0);
        @(posedge aclk);
        #1 areset = 1'b0;

        // Iteration A: k=1, 21 config beats, early tlast on beat 5, no FILL.
        cfg_n = 0;
        cfg_iter(8'h23, 21, 5);
        chk("A_cfg_count", 64'(cfg_n), 64'd21);
        chk("A_err_count", 64'(err_n), 64'd1);
        chk("A_kernel", {62'd0, m_cfg_kernel}, 64'd1);
        @(negedge aclk);
        chk("A_no_fill", {63'd0, s_axis_tready}, 64'd1);
        @(posedge aclk);
        #1;
        nar_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            pass_beat(a_lo[i], a_hi[i], a_u[i], (i == 3));
            if (i == 0) chk("A_first_latency", {63'd0, m_data_tvalid}, 64'd1);
        end
        wait_clear();
        chk("A_nar_left", 64'(nar_exp.size()), 64'd0);
        chk("A_nar_count", 64'(nar_cyc.size()), 64'd8);
        if (nar_cyc.size() == 8) chk("A_no_bubble", 64'(nar_cyc[7] - nar_cyc[0]), 64'd7);
        @(negedge aclk);
        chk("A_clear_once", {62'd0, cfg_clear, s_axis_tready}, 64'd1);
        chk("A_clr_count", 64'(clr_n), 64'd1);
        @(posedge aclk);
        #1;

        // Iteration B: k=0, FILL at full ready, then a 5-cycle stall mid-beat.
        cfg_iter(8'h81, 13, 0);
        chk("B_kernel", {62'd0, m_cfg_kernel}, 64'd0);
        fill_len(1'b0, fl);
        chk("B_fill_len", 64'(fl), 64'd3);
        m_data_tready = 1'b1;
        nar_cyc.delete();
        pass_beat(32'h1234_5678, 32'h9ABC_DEF0, 8'h5C, 1'b0);
        @(posedge aclk);
        #1 m_data_tready = 1'b0;
        fork
            pass_beat(32'h0F0F_0F0F, 32'hF0F0_F0F0, 8'hE1, 1'b1);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_data", {31'd0, m_data_tdata, m_data_tlast}, {31'd0, 32'h9ABC_DEF0, 1'b0});
            chk("stall_blocked", {62'd0, m_data_tvalid, s_axis_tready}, 64'd2);
            @(posedge aclk);
            #1;
        end
        m_data_tready = 1'b1;
        wait_clear();
        chk("B_nar_left", 64'(nar_exp.size()), 64'd0);
        chk("B_nar_count", 64'(nar_cyc.size()), 64'd4);
        if (nar_cyc.size() == 4) chk("B_no_bubble", 64'(nar_cyc[3] - nar_cyc[1]), 64'd2);
        @(posedge aclk);
        #1;

        // Iteration C: k=0 with toggling engine enable, then reset in DRAIN.
        cfg_iter(8'h9E, 13, 0);
        fill_len(1'b1, fl);
        chk("C_fill_len", 64'(fl), 64'd6);
        m_data_tready = 1'b0;
        put(64'h7777_8888_9999_AAAA, 8'h66, 1'b1);
        areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("C_rst_outputs", {62'd0, m_data_tvalid, cfg_clear}, 64'd0);
        chk("C_rst_cfg_first", {63'd0, s_axis_tready}, 64'd1);
        m_cfg_tready = 1'b0;
        #1;
        chk("C_rst_passthru", {63'd0, s_axis_tready}, 64'd0);
        m_cfg_tready  = 1'b1;
        m_data_tready = 1'b1;
        chk("C_clr_count", 64'(clr_n), 64'd2);
        @(posedge aclk);
        #1;

        // Iteration D: k=2 recovery after reset, single data beat.
        cfg_n = 0;
        cfg_iter(8'h40, 29, 0);
        chk("D_cfg_count", 64'(cfg_n), 64'd29);
        chk("D_kernel", {62'd0, m_cfg_kernel}, 64'd2);
        pass_beat(32'h0000_0001, 32'h8000_0000, 8'h9F, 1'b1);
        wait_clear();
        chk("D_nar_left", 64'(nar_exp.size()), 64'd0);
        chk("D_cfg_left", 64'(cfg_exp.size()), 64'd0);
        chk("err_total", 64'(err_n), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule
